// File: rtl/hilo_muldiv_seq.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU sequencer, 34 cycles from start to done.
// Raises stall_req while busy; MTHI/MTLO are accepted only when idle.
module hilo_muldiv_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ITER_CNT   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  cancel,
  input  logic                  hi_write_en,
  input  logic                  lo_write_en,
  input  logic [DATA_WIDTH-1:0] hilo_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITER_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER_CNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_a, r_b, r_op1, r_hi, r_lo;
  logic            r_is_div, r_neg_a, r_neg_b, r_done;

  logic            w_busy, w_accept, w_commit;
  logic            w_signed, w_neg_a, w_neg_b, w_sign_diff;
  logic [W-1:0]    w_mag_a, w_mag_b;
  logic [W:0]      w_madd;
  logic [2*W-1:0]  w_mul_nxt, w_div_nxt, w_prod;
  logic [W:0]      w_part;
  logic [W+1:0]    w_diff;
  logic [W-1:0]    w_quo, w_rem, w_new_hi, w_new_lo;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !cancel) w_next = S_CALC;
      S_CALC:  if (cancel) w_next = S_IDLE;
               else if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_accept = (r_state == S_IDLE) && start && !cancel;
    w_commit = (r_state == S_FIX) && !cancel;
  end

  // Operand magnitudes; only MULT and DIV (op[0]==0) treat operands as signed.
  assign w_signed = ~op[0];
  assign w_neg_a  = w_signed & operand_1[W-1];
  assign w_neg_b  = w_signed & operand_2[W-1];
  assign w_mag_a  = w_neg_a ? (~operand_1 + 1'b1) : operand_1;
  assign w_mag_b  = w_neg_b ? (~operand_2 + 1'b1) : operand_2;

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign w_madd    = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
  assign w_mul_nxt = {w_madd, r_acc[W-1:1]};

  // Restoring divide on {rem,quo}; the shifted partial remainder needs W+1 bits.
  assign w_part    = r_acc[2*W-1:W-1];
  assign w_diff    = {1'b0, w_part} - {2'b00, r_b};
  assign w_div_nxt = w_diff[W+1] ? {r_acc[2*W-2:0], 1'b0}
                                 : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};

  assign w_sign_diff = r_neg_a ^ r_neg_b;
  assign w_prod = w_sign_diff ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = w_sign_diff ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
  assign w_rem  = r_neg_a ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];

  always_comb begin
    w_new_hi = w_prod[2*W-1:W];
    w_new_lo = w_prod[W-1:0];
    if (r_is_div) begin
      if (r_b == '0) begin
        w_new_hi = r_op1;
        w_new_lo = '1;
      end else begin
        w_new_hi = w_rem;
        w_new_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op1    <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_a      <= w_mag_a;
        r_b      <= w_mag_b;
        r_op1    <= operand_1;
        r_is_div <= op[1];
        r_neg_a  <= w_neg_a;
        r_neg_b  <= w_neg_b;
        r_acc    <= op[1] ? {{W{1'b0}}, w_mag_a} : {{W{1'b0}}, w_mag_b};
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
      end

      // MTHI/MTLO land only while idle; a commit can never coincide with idle.
      if (w_commit) begin
        r_hi <= w_new_hi;
        r_lo <= w_new_lo;
      end else if (r_state == S_IDLE) begin
        if (hi_write_en) r_hi <= hilo_write_data;
        if (lo_write_en) r_lo <= hilo_write_data;
      end
      r_done <= w_commit;
    end
  end

  assign busy      = w_busy;
  assign stall_req = start | w_busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
endmodule

// File: doc/hilo_muldiv_seq.md
Name: hilo_muldiv_seq

Overview:
Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the architectural HI/LO registers.
- Sits beside the EX stage. EX issues a start pulse with operands; this block iterates 32 cycles and commits HI/LO.
- While an operation is in flight it raises a stall request so the pipeline holds.
- Also services MTHI/MTLO writes and provides HI/LO to EX for MFHI/MFLO.

Parameters:
- DATA_WIDTH, 32, operand / HI / LO width.
- ITER_CNT, 32, shift-add / restoring-divide iterations (equals DATA_WIDTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_1  input  32  multiplicand / dividend (rs).
- operand_2  input  32  multiplier / divisor (rt).
- cancel  input  1  pipeline flush; aborts the in-flight operation.
- hi_write_en  input  1  MTHI.
- lo_write_en  input  1  MTLO.
- hilo_write_data  input  32  data for MTHI/MTLO.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: HI/LO just committed.
- stall_req  output  1  combinational: start | busy.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0; iteration counter and working registers cleared. Reset mid-operation aborts with no commit.
- States: IDLE, CALC, FIX.
- IDLE → CALC when start=1 and cancel=0 (start sampled at edge N). Latch op, sign flags and magnitudes:
  - signed op with negative operand → two's complement; unsigned op → operand as is.
  - counter=0.
- CALC, MULT*: shift-add on the 64-bit accumulator, one bit per cycle.
- CALC, DIV*: restoring divide; each cycle shift {rem,quo} left, trial-subtract divisor magnitude, set quotient bit if no borrow.
- CALC → FIX after ITER_CNT cycles (cycles N+1..N+32).
- FIX (cycle N+33): sign correction, committed at the edge ending the cycle.
  - MULT: 64-bit product negated if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - HI←product[63:32] / remainder; LO←product[31:0] / quotient.
  - Next state IDLE.
- done=1 during cycle N+34 only, with new hi/lo visible. busy=1 during cycles N+1..N+33.
- Fixed latency: 34 cycles start-to-done for all ops, including divide-by-zero.
- Divide by zero (DIV or DIVU): LO=32'hFFFFFFFF, HI=operand_1 (original, uncorrected).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap); no trap.
- start while busy: ignored (EX is stalled by stall_req).
- cancel in CALC/FIX: next state IDLE, HI/LO unchanged, no done pulse. cancel in IDLE: start that cycle ignored.
- MTHI/MTLO in IDLE (including the done cycle): write at the edge.
- MTHI/MTLO while busy: dropped.
- MTHI/MTLO in the same cycle as an accepted start: the write applies; the later commit overwrites both.
- hi/lo are register outputs with no bypass; MFHI in the done cycle reads new values.

Test Plan:
- MULT operand_1=0xFFFFFFFD (−3), operand_2=5 → done at N+34; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly N+1..N+33.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT of the same operands → hi=0, lo=1.
- DIV −7/2 (0xFFFFFFF9, 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIVU 7/0 → lo=0xFFFFFFFF, hi=7 after 34 cycles.
- Preload hi=0x1234 via MTHI, start MULTU, assert cancel at N+10 → busy low at N+11, no done, hi=0x1234. Repeat with rst at N+10 → hi=lo=0.
- During busy: pulse start with new operands and MTLO 0xAAAA → both ignored; result matches the original operands. MTLO in the done cycle → lo=0xAAAA next cycle.
